// File: rtl/fault_tolerant_ctrl.sv
// fault_tolerant_ctrl: masks writes on decoder/stuck-at faults, flushes, rolls the PC back to the checkpoint and retries, halting after repeated faults.
module fault_tolerant_ctrl #(
  parameter int MAX_RETRIES  = 2,
  parameter int CLEAN_WINDOW = 8,
  parameter int PC_WIDTH     = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                illegal_opcode,
  input  logic                invalid_control,
  input  logic                stuck_at_fault,
  input  logic                pc_write_normal,
  input  logic                reg_write_normal,
  input  logic                mem_write_normal,
  input  logic [PC_WIDTH-1:0] pc_current,
  input  logic [PC_WIDTH-1:0] pc_saved,
  output logic                pc_write_out,
  output logic                reg_write_out,
  output logic                mem_write_out,
  output logic [PC_WIDTH-1:0] pc_next,
  output logic                insert_nop,
  output logic                retry_en
);
  localparam logic [1:0] NORMAL = 2'd0, FLUSH = 2'd1, RETRY = 2'd2, SAFE = 2'd3;
  localparam int RW = $clog2(MAX_RETRIES + 1);
  localparam int CW = $clog2(CLEAN_WINDOW + 1);
  logic [1:0]    state_q, state_d;
  logic [RW-1:0] retry_cnt_q, retry_cnt_d;
  logic [CW-1:0] clean_cnt_q, clean_cnt_d;
  logic          fault, can_retry;
  assign fault     = illegal_opcode | invalid_control | stuck_at_fault;
  assign can_retry = retry_cnt_q < RW'(MAX_RETRIES);
  always_comb begin
    state_d       = state_q;
    retry_cnt_d   = retry_cnt_q;
    clean_cnt_d   = clean_cnt_q;
    pc_write_out  = 1'b0;
    reg_write_out = 1'b0;
    mem_write_out = 1'b0;
    pc_next       = pc_current;
    insert_nop    = 1'b0;
    retry_en      = 1'b0;
    case (state_q)
      NORMAL: begin
        if (fault) begin
          insert_nop  = 1'b1;
          state_d     = can_retry ? FLUSH : SAFE;
          retry_cnt_d = can_retry ? retry_cnt_q + RW'(1) : retry_cnt_q;
          clean_cnt_d = '0;
        end else begin
          pc_write_out  = pc_write_normal;
          reg_write_out = reg_write_normal;
          mem_write_out = mem_write_normal;
          retry_cnt_d   = (clean_cnt_q == CW'(CLEAN_WINDOW - 1)) ? '0 : retry_cnt_q;
          clean_cnt_d   = (clean_cnt_q == CW'(CLEAN_WINDOW - 1)) ? '0 : clean_cnt_q + CW'(1);
        end
      end
      FLUSH: begin
        insert_nop = 1'b1;
        pc_next    = pc_saved;
        state_d    = RETRY;
      end
      RETRY: begin
        pc_write_out = 1'b1;
        insert_nop   = 1'b1;
        retry_en     = 1'b1;
        pc_next      = pc_saved;
        state_d      = NORMAL;
      end
      default: begin
        insert_nop = 1'b1;
        pc_next    = pc_saved;
      end
    endcase
    // outputs must be quiet while reset is held, regardless of the registered state
    if (!reset) begin
      pc_write_out  = 1'b0;
      reg_write_out = 1'b0;
      mem_write_out = 1'b0;
      pc_next       = pc_current;
      insert_nop    = 1'b0;
      retry_en      = 1'b0;
    end
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= NORMAL;
      retry_cnt_q <= '0;
      clean_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      retry_cnt_q <= retry_cnt_d;
      clean_cnt_q <= clean_cnt_d;
    end
  end
endmodule

// File: tb/tb_fault_tolerant_ctrl.sv
// tb_fault_tolerant_ctrl: directed scoreboard bench for fault masking, flush/retry recovery, retry window and safe halt.
module tb_fault_tolerant_ctrl;
  localparam int K_NORM = 0, K_FAULT = 1, K_FLUSH = 2, K_RETRY = 3, K_SAFE = 4, K_RST = 5;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        illegal_opcode = 1'b0, invalid_control = 1'b0, stuck_at_fault = 1'b0;
  logic        pc_write_normal = 1'b1, reg_write_normal = 1'b1, mem_write_normal = 1'b1;
  logic [31:0] pc_current = 32'h10, pc_saved = 32'h08;
  logic        pc_write_out, reg_write_out, mem_write_out, insert_nop, retry_en;
  logic [31:0] pc_next;
  int          checks = 0, failures = 0;
  logic [36:0] exp_q[$];
  string       tag_q[$];

  fault_tolerant_ctrl dut (
    .clk(clk), .reset(reset),
    .illegal_opcode(illegal_opcode), .invalid_control(invalid_control), .stuck_at_fault(stuck_at_fault),
    .pc_write_normal(pc_write_normal), .reg_write_normal(reg_write_normal), .mem_write_normal(mem_write_normal),
    .pc_current(pc_current), .pc_saved(pc_saved),
    .pc_write_out(pc_write_out), .reg_write_out(reg_write_out), .mem_write_out(mem_write_out),
    .pc_next(pc_next), .insert_nop(insert_nop), .retry_en(retry_en)
  );

  always #5 clk = ~clk;

  // {pc_write, reg_write, mem_write, pc_next, insert_nop, retry_en}
  function automatic logic [36:0] expect_of(int k);
    case (k)
      K_NORM:  return {pc_write_normal, reg_write_normal, mem_write_normal, pc_current, 1'b0, 1'b0};
      K_FAULT: return {3'b000, pc_current, 1'b1, 1'b0};
      K_FLUSH: return {3'b000, pc_saved, 1'b1, 1'b0};
      K_RETRY: return {3'b100, pc_saved, 1'b1, 1'b1};
      K_SAFE:  return {3'b000, pc_saved, 1'b1, 1'b0};
      default: return {3'b000, pc_current, 1'b0, 1'b0};
    endcase
  endfunction

  task automatic check_now();
    logic [36:0] e, o;
    string t;
    #1;
    e = exp_q.pop_front();
    t = tag_q.pop_front();
    o = {pc_write_out, reg_write_out, mem_write_out, pc_next, insert_nop, retry_en};
    checks++;
    assert (o === e) else begin
      failures++;
      $error("FAIL %s: observed=%h expected=%h", t, o, e);
    end
  endtask

  task automatic step(input logic [2:0] flt, input int k, input string t);
    @(negedge clk);
    {illegal_opcode, invalid_control, stuck_at_fault} = flt;
    exp_q.push_back(expect_of(k));
    tag_q.push_back(t);
    check_now();
  endtask

  task automatic async_reset(input string t);
    #2 reset = 1'b0;
    exp_q.push_back(expect_of(K_RST));
    tag_q.push_back(t);
    check_now();
    step(3'b000, K_RST, {t, "_held"});
    reset = 1'b1;
  endtask

  initial begin
    step(3'b000, K_RST, "reset_gates_writes");
    reset = 1'b1;
    step(3'b000, K_NORM, "release_pass");
    {pc_write_normal, reg_write_normal, mem_write_normal} = 3'b010;
    step(3'b000, K_NORM, "pass_pattern_010");
    {pc_write_normal, reg_write_normal, mem_write_normal} = 3'b111;
    step(3'b100, K_FAULT, "illegal_mask");
    step(3'b100, K_FLUSH, "illegal_flush_held");
    step(3'b000, K_RETRY, "illegal_retry");
    step(3'b000, K_NORM, "illegal_resume");
    repeat (3) step(3'b000, K_NORM, "clean_gap");
    step(3'b001, K_FAULT, "stuck_mask");
    step(3'b001, K_FLUSH, "stuck_flush");
    step(3'b000, K_RETRY, "stuck_retry");
    step(3'b000, K_NORM, "stuck_resume");
    step(3'b100, K_FAULT, "third_mask");
    repeat (4) step(3'b000, K_SAFE, "safe_hold");
    step(3'b010, K_SAFE, "safe_ignores_fault");
    async_reset("safe_reset");
    step(3'b000, K_NORM, "after_safe_reset");
    pc_saved = 32'hDEAD_BEE8;
    pc_current = 32'hF000_0A04;
    step(3'b110, K_FAULT, "dual_mask");
    step(3'b000, K_FLUSH, "dual_flush_pc32");
    step(3'b000, K_RETRY, "dual_retry_pc32");
    step(3'b000, K_NORM, "dual_resume");
    step(3'b010, K_FAULT, "second_mask");
    step(3'b000, K_FLUSH, "dual_counted_once");
    step(3'b000, K_RETRY, "second_retry");
    repeat (8) step(3'b000, K_NORM, "window_clean");
    step(3'b001, K_FAULT, "post_window_mask");
    step(3'b000, K_FLUSH, "window_cleared_cnt");
    step(3'b000, K_RETRY, "post_window_retry");
    step(3'b100, K_FAULT, "held_new_fault_mask");
    step(3'b000, K_FLUSH, "second_after_window");
    step(3'b000, K_RETRY, "retry_before_reset");
    async_reset("retry_reset");
    step(3'b000, K_NORM, "after_retry_reset");
    step(3'b100, K_FAULT, "fresh_cnt_mask");
    step(3'b000, K_FLUSH, "fresh_cnt_flush");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
